// File: rtl/fpu_op_sequencer_pkg.sv
// Shared constants for the FP op sequencer: FP op codes, reserved code, FSM state encoding
// and the destination-class helper used by the op decoder.
package fpu_op_sequencer_pkg;

  localparam logic [4:0] FOPADD   = 5'h00;
  localparam logic [4:0] FOPSUB   = 5'h01;
  localparam logic [4:0] FOPMUL   = 5'h02;
  localparam logic [4:0] FOPDIV   = 5'h03;
  localparam logic [4:0] FOPSQRT  = 5'h04;
  localparam logic [4:0] FOPSGNJ  = 5'h05;
  localparam logic [4:0] FOPSGNJN = 5'h06;
  localparam logic [4:0] FOPSGNJX = 5'h07;
  localparam logic [4:0] FOPMIN   = 5'h08;
  localparam logic [4:0] FOPMAX   = 5'h09;
  localparam logic [4:0] FOPCVTSW = 5'h0A;
  localparam logic [4:0] FOPCVTWS = 5'h0B;
  localparam logic [4:0] FOPMVXW  = 5'h0C;
  localparam logic [4:0] FOPMVWX  = 5'h0D;
  localparam logic [4:0] FOPEQ    = 5'h0E;
  localparam logic [4:0] FOPLT    = 5'h0F;
  localparam logic [4:0] FOPLE    = 5'h10;
  localparam logic [4:0] FOPRSVD  = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2,
    ST_RSVD = 2'd3
  } seqState_t;

  // Ops whose result lands in the integer register file.
  function automatic logic isIntDest(input logic [4:0] op);
    return op inside {FOPEQ, FOPLT, FOPLE, FOPCVTWS, FOPMVXW};
  endfunction

endpackage

// File: rtl/fpu_op_sequencer_decode.sv
// Combinational FP op table: op code -> {legal, latency, integer destination}.
// The only place op latencies are assigned; a latency of 0 is treated as 1.
module fpu_op_decode
  import fpu_op_sequencer_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int LAT_ADD = 7,
  parameter int LAT_MUL = 5,
  parameter int LAT_DIV = 6,
  parameter int LAT_CVT = 6,
  parameter int LAT_SMP = 1
) (
  input  logic [4:0]       op,
  output logic             legal,
  output logic [CNT_W-1:0] lat,
  output logic             toInt
);

  function automatic logic [CNT_W-1:0] clampLat(input int l);
    return (l <= 0) ? CNT_W'(1) : CNT_W'(l);
  endfunction

  always_comb begin
    legal = 1'b1;
    lat   = clampLat(LAT_SMP);
    toInt = isIntDest(op);
    case (op)
      FOPADD, FOPSUB:     lat = clampLat(LAT_ADD);
      FOPMUL:             lat = clampLat(LAT_MUL);
      FOPDIV, FOPSQRT:    lat = clampLat(LAT_DIV);
      FOPCVTSW, FOPCVTWS: lat = clampLat(LAT_CVT);
      FOPSGNJ, FOPSGNJN, FOPSGNJX, FOPMIN, FOPMAX,
      FOPMVXW, FOPMVWX, FOPEQ, FOPLT, FOPLE: lat = clampLat(LAT_SMP);
      default: begin
        legal = 1'b0;
        lat   = '0;
        toInt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Multicycle sequencer for the pipelined FPALU: stalls the core for the op latency and
// emits one writeback strobe. Optional performance counters under FPU_SEQ_PERF_CNT_EN.
module fpu_op_sequencer
  import fpu_op_sequencer_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int LAT_ADD = 7,
  parameter int LAT_MUL = 5,
  parameter int LAT_DIV = 6,
  parameter int LAT_CVT = 6,
  parameter int LAT_SMP = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  input  logic [4:0]  iFPALUControl,
  input  logic        iFlush,
  output logic        oStall,
  output logic        oFPRegWrite,
  output logic        oIntRegWrite,
  output logic        oBusy,
  output logic        oIllegal,
  output logic [1:0]  oState,
  output logic [31:0] oStallCycles,
  output logic [31:0] oFPOps
);

  seqState_t        state, nextState;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             toIntQ, toIntNext;
  logic             illegalQ, illegalNext;
  logic             decLegal, decToInt;
  logic [CNT_W-1:0] decLat;
  logic             accept;

  fpu_op_decode #(
    .CNT_W  (CNT_W),
    .LAT_ADD(LAT_ADD),
    .LAT_MUL(LAT_MUL),
    .LAT_DIV(LAT_DIV),
    .LAT_CVT(LAT_CVT),
    .LAT_SMP(LAT_SMP)
  ) uDecode (
    .op   (iFPALUControl),
    .legal(decLegal),
    .lat  (decLat),
    .toInt(decToInt)
  );

  assign accept = (state == ST_IDLE) && iStart && decLegal && !iFlush;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      toIntQ   <= 1'b0;
      illegalQ <= 1'b0;
    end else begin
      state    <= nextState;
      cnt      <= cntNext;
      toIntQ   <= toIntNext;
      illegalQ <= illegalNext;
    end
  end

  always_comb begin
    nextState   = state;
    cntNext     = cnt;
    toIntNext   = toIntQ;
    illegalNext = 1'b0;
    case (state)
      ST_IDLE: begin
        illegalNext = iStart && !decLegal && !iFlush;
        if (accept) begin
          nextState = ST_EXEC;
          cntNext   = decLat;
          toIntNext = decToInt;
        end
      end
      ST_EXEC: begin
        cntNext = cnt - CNT_W'(1);
        if (iFlush) begin
          nextState = ST_IDLE;
          cntNext   = '0;
        end else if (cnt <= CNT_W'(1)) begin
          nextState = ST_WB;
        end
      end
      ST_WB: begin
        nextState = ST_IDLE;
        cntNext   = '0;
      end
      default: begin
        nextState = ST_IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // Stall is gated by reset so every output reads 0 while iRST is low.
  assign oStall       = iRST && (accept || (state == ST_EXEC));
  assign oFPRegWrite  = (state == ST_WB) && !toIntQ && !iFlush;
  assign oIntRegWrite = (state == ST_WB) &&  toIntQ && !iFlush;
  assign oBusy        = (state != ST_IDLE);
  assign oIllegal     = illegalQ;
  assign oState       = state;

`ifdef FPU_SEQ_PERF_CNT_EN
  logic [31:0] stallCnt, opCnt;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      stallCnt <= '0;
      opCnt    <= '0;
    end else begin
      if (oStall && (stallCnt != 32'hFFFF_FFFF)) stallCnt <= stallCnt + 32'd1;
      if ((oFPRegWrite || oIntRegWrite) && (opCnt != 32'hFFFF_FFFF)) opCnt <= opCnt + 32'd1;
    end
  end

  assign oStallCycles = stallCnt;
  assign oFPOps       = opCnt;
`else
  assign oStallCycles = 32'h0;
  assign oFPOps       = 32'h0;
`endif

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer; expectations come from a latency/class table
// and cycle arithmetic. Counter checks follow FPU_SEQ_PERF_CNT_EN.
module tb_fpu_op_sequencer;
  import fpu_op_sequencer_pkg::*;

  localparam int CNT_W = 4, LAT_ADD = 7, LAT_MUL = 5, LAT_DIV = 6, LAT_CVT = 6, LAT_SMP = 1;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iStart = 1'b0;
  logic [4:0]  iFPALUControl = 5'h0;
  logic        iFlush = 1'b0;
  logic        oStall, oFPRegWrite, oIntRegWrite, oBusy, oIllegal;
  logic [1:0]  oState;
  logic [31:0] oStallCycles, oFPOps;

  int nChecks = 0;
  int nFails  = 0;
  int expStall = 0;
  int expOps   = 0;

  logic [4:0] legalOps [17] = '{FOPADD, FOPSUB, FOPMUL, FOPDIV, FOPSQRT, FOPSGNJ, FOPSGNJN,
                                FOPSGNJX, FOPMIN, FOPMAX, FOPCVTSW, FOPCVTWS, FOPMVXW,
                                FOPMVWX, FOPEQ, FOPLT, FOPLE};

  fpu_op_sequencer #(
    .CNT_W(CNT_W), .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL),
    .LAT_DIV(LAT_DIV), .LAT_CVT(LAT_CVT), .LAT_SMP(LAT_SMP)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iFPALUControl(iFPALUControl),
    .iFlush(iFlush), .oStall(oStall), .oFPRegWrite(oFPRegWrite),
    .oIntRegWrite(oIntRegWrite), .oBusy(oBusy), .oIllegal(oIllegal), .oState(oState),
    .oStallCycles(oStallCycles), .oFPOps(oFPOps)
  );

  always #5 iCLK = ~iCLK;

  // Reference table: latency and destination class by instruction family.
  function automatic int expLat(input logic [4:0] op);
    int l;
    case (op)
      FOPADD, FOPSUB:     l = LAT_ADD;
      FOPMUL:             l = LAT_MUL;
      FOPDIV, FOPSQRT:    l = LAT_DIV;
      FOPCVTSW, FOPCVTWS: l = LAT_CVT;
      default:            l = LAT_SMP;
    endcase
    return (l < 1) ? 1 : l;
  endfunction

  function automatic logic expInt(input logic [4:0] op);
    return (op == FOPEQ) || (op == FOPLT) || (op == FOPLE) || (op == FOPCVTWS) || (op == FOPMVXW);
  endfunction

  function automatic logic [31:0] perfExp(input int v);
`ifdef FPU_SEQ_PERF_CNT_EN
    return 32'(v);
`else
    return 32'h0 & 32'(v);
`endif
  endfunction

  // One cycle: inputs change just after the rising edge, outputs are sampled on the falling edge.
  task automatic cyc(input logic s, input logic [4:0] op, input logic f);
    @(posedge iCLK);
    #1;
    iStart = s;
    iFPALUControl = op;
    iFlush = f;
    @(negedge iCLK);
  endtask

  task automatic test_reset();
    iRST = 1'b0;
    cyc(1'b1, FOPADD, 1'b0);
    nChecks++;
    if ({oStall, oFPRegWrite, oIntRegWrite, oBusy, oIllegal, oState} !== 7'b0 ||
        oStallCycles !== 32'h0 || oFPOps !== 32'h0) begin
      nFails++;
      $display("FAIL reset_outputs: got %b/%0h/%0h expected all zero",
               {oStall, oFPRegWrite, oIntRegWrite, oBusy, oIllegal, oState}, oStallCycles, oFPOps);
    end
    @(posedge iCLK);
    #1;
    iRST = 1'b1;
    iStart = 1'b0;
    @(negedge iCLK);
    nChecks++;
    if (oState !== 2'd0 || oStall !== 1'b0) begin
      nFails++;
      $display("FAIL reset_release: state %0d stall %b expected 0 0", oState, oStall);
    end
    expStall = 0;
    expOps = 0;
  endtask

  task automatic test_fadd();
    for (int t = 0; t <= 9; t++) begin
      cyc(t <= 8, (t == 0) ? FOPADD : 5'($urandom), 1'b0);
      nChecks++;
      if (oStall !== (t <= 7) || oFPRegWrite !== (t == 8) || oIntRegWrite !== 1'b0) begin
        nFails++;
        $display("FAIL fadd_c%0d: stall/fp/int %b%b%b expected %b%b0", t, oStall, oFPRegWrite,
                 oIntRegWrite, t <= 7, t == 8);
      end
    end
    nChecks++;
    if (oState !== 2'd0 || oBusy !== 1'b0) begin
      nFails++;
      $display("FAIL fadd_idle: state %0d busy %b expected 0 0", oState, oBusy);
    end
    expStall += 8;
    expOps += 1;
    nChecks++;
    if (oStallCycles !== perfExp(expStall) || oFPOps !== perfExp(expOps)) begin
      nFails++;
      $display("FAIL fadd_perf: got %0d/%0d expected %0d/%0d", oStallCycles, oFPOps,
               perfExp(expStall), perfExp(expOps));
    end
  endtask

  task automatic test_fle();
    for (int t = 0; t <= 3; t++) begin
      cyc(t <= 2, FOPLE, 1'b0);
      nChecks++;
      if (oStall !== (t <= 1) || oIntRegWrite !== (t == 2) || oFPRegWrite !== 1'b0) begin
        nFails++;
        $display("FAIL fle_c%0d: stall/fp/int %b%b%b expected %b0%b", t, oStall, oFPRegWrite,
                 oIntRegWrite, t <= 1, t == 2);
      end
    end
    expStall += 2;
    expOps += 1;
  endtask

  task automatic test_back_to_back();
    logic expS;
    for (int t = 0; t <= 15; t++) begin
      cyc(t <= 14, (t <= 6) ? FOPMUL : FOPDIV, 1'b0);
      expS = (t <= 14) && (t != 6) && (t != 14);
      nChecks++;
      if (oStall !== expS || oFPRegWrite !== (t == 6 || t == 14) || oIntRegWrite !== 1'b0) begin
        nFails++;
        $display("FAIL b2b_c%0d: stall/fp/int %b%b%b expected %b%b0", t, oStall, oFPRegWrite,
                 oIntRegWrite, expS, t == 6 || t == 14);
      end
    end
    expStall += 13;
    expOps += 2;
  endtask

  task automatic test_random_ops();
    logic [4:0] op;
    int l, gap;
    logic ti;
    logic [1:0] expSt;
    for (int k = 0; k < 12; k++) begin
      op = legalOps[$urandom_range(0, 16)];
      l = expLat(op);
      ti = expInt(op);
      for (int t = 0; t <= l + 1; t++) begin
        cyc(1'b1, (t == 0) ? op : 5'($urandom), 1'b0);
        expSt = (t == 0) ? 2'd0 : (t <= l) ? 2'd1 : 2'd2;
        nChecks++;
        if (oStall !== (t <= l) || oFPRegWrite !== (t == l + 1 && !ti) ||
            oIntRegWrite !== (t == l + 1 && ti) || oState !== expSt) begin
          nFails++;
          $display("FAIL rand_op%0h_c%0d: stall/fp/int/st %b%b%b/%0d expected %b%b%b/%0d", op, t,
                   oStall, oFPRegWrite, oIntRegWrite, oState, t <= l, t == l + 1 && !ti,
                   t == l + 1 && ti, expSt);
        end
      end
      expStall += l + 1;
      expOps += 1;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        cyc(1'b0, 5'($urandom), 1'b0);
        nChecks++;
        if (oStall !== 1'b0 || oState !== 2'd0) begin
          nFails++;
          $display("FAIL rand_gap: stall %b state %0d expected 0 0", oStall, oState);
        end
      end
    end
    nChecks++;
    if (oStallCycles !== perfExp(expStall) || oFPOps !== perfExp(expOps)) begin
      nFails++;
      $display("FAIL rand_perf: got %0d/%0d expected %0d/%0d", oStallCycles, oFPOps,
               perfExp(expStall), perfExp(expOps));
    end
  endtask

  task automatic test_flush();
    logic [4:0] op;
    int l, f;
    for (int k = 0; k < 6; k++) begin
      op = (k == 0) ? FOPDIV : legalOps[$urandom_range(0, 16)];
      l = expLat(op);
      f = (k == 0) ? 3 : (k == 1) ? l + 1 : $urandom_range(1, l + 1);
      for (int t = 0; t <= f; t++) begin
        cyc(1'b1, op, t == f);
        nChecks++;
        if (oStall !== (t <= l) || oFPRegWrite !== 1'b0 || oIntRegWrite !== 1'b0) begin
          nFails++;
          $display("FAIL flush_op%0h_f%0d_c%0d: stall/fp/int %b%b%b expected %b00", op, f, t,
                   oStall, oFPRegWrite, oIntRegWrite, t <= l);
        end
      end
      expStall += ((f < l) ? f : l) + 1;
      cyc(1'b1, op, 1'b1);
      nChecks++;
      if (oStall !== 1'b0 || oState !== 2'd0) begin
        nFails++;
        $display("FAIL flush_start: stall %b state %0d expected 0 0", oStall, oState);
      end
      cyc(1'b0, op, 1'b0);
      nChecks++;
      if (oState !== 2'd0 || oFPRegWrite !== 1'b0 || oIntRegWrite !== 1'b0) begin
        nFails++;
        $display("FAIL flush_idle: state %0d fp %b int %b expected 0 0 0", oState, oFPRegWrite,
                 oIntRegWrite);
      end
    end
    nChecks++;
    if (oStallCycles !== perfExp(expStall) || oFPOps !== perfExp(expOps)) begin
      nFails++;
      $display("FAIL flush_perf: got %0d/%0d expected %0d/%0d", oStallCycles, oFPOps,
               perfExp(expStall), perfExp(expOps));
    end
  endtask

  task automatic test_illegal();
    logic [4:0] op;
    for (int k = 0; k < 4; k++) begin
      op = (k == 0) ? FOPRSVD : 5'($urandom_range(5'h11, 5'h1F));
      cyc(1'b1, op, 1'b0);
      nChecks++;
      if (oStall !== 1'b0 || oIllegal !== 1'b0 || oState !== 2'd0) begin
        nFails++;
        $display("FAIL illegal_%0h_c0: stall %b illegal %b state %0d expected 0 0 0", op, oStall,
                 oIllegal, oState);
      end
      cyc(1'b0, op, 1'b0);
      nChecks++;
      if (oIllegal !== 1'b1 || oStall !== 1'b0) begin
        nFails++;
        $display("FAIL illegal_%0h_c1: illegal %b stall %b expected 1 0", op, oIllegal, oStall);
      end
      cyc(1'b0, op, 1'b0);
      nChecks++;
      if (oIllegal !== 1'b0) begin
        nFails++;
        $display("FAIL illegal_%0h_c2: illegal %b expected 0", op, oIllegal);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int t = 0; t <= 3; t++) cyc(1'b1, FOPADD, 1'b0);
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    @(negedge iCLK);
    nChecks++;
    if ({oStall, oFPRegWrite, oIntRegWrite, oBusy, oIllegal, oState} !== 7'b0 ||
        oStallCycles !== 32'h0 || oFPOps !== 32'h0) begin
      nFails++;
      $display("FAIL reset_mid: got %b/%0h/%0h expected all zero",
               {oStall, oFPRegWrite, oIntRegWrite, oBusy, oIllegal, oState}, oStallCycles, oFPOps);
    end
    expStall = 0;
    expOps = 0;
    @(posedge iCLK);
    #1;
    iRST = 1'b1;
    iStart = 1'b0;
    for (int t = 0; t < 10; t++) begin
      cyc(1'b0, FOPADD, 1'b0);
      nChecks++;
      if (oState !== 2'd0 || oFPRegWrite !== 1'b0 || oIntRegWrite !== 1'b0 || oStall !== 1'b0) begin
        nFails++;
        $display("FAIL reset_mid_after_c%0d: state %0d fp %b int %b stall %b expected 0 0 0 0", t,
                 oState, oFPRegWrite, oIntRegWrite, oStall);
      end
    end
    nChecks++;
    if (oStallCycles !== perfExp(expStall) || oFPOps !== perfExp(expOps)) begin
      nFails++;
      $display("FAIL reset_mid_perf: got %0d/%0d expected 0/0", oStallCycles, oFPOps);
    end
  endtask

  initial begin
    test_reset();
    test_fadd();
    test_fle();
    test_back_to_back();
    test_random_ops();
    test_flush();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
